// File: rtl/vid_line_fetch_ctrl.sv
// Line-fetch sequencer: walks the frame buffer line by line, issues fixed 4-beat
// read bursts while the pixel FIFOs have room, and steers returned beats into them.
module vid_line_fetch_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int BURST      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] base_addr,
    input  logic [31:0] lineinc,
    input  logic [12:0] hsize,
    input  logic [12:0] vsize,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [4:0]  fifo_level,
    input  logic        gnt,
    input  logic        beat_valid,
    input  logic [31:0] rd_data,
    output logic        req,
    output logic [2:0]  cmd_out,
    output logic [1:0]  len_out,
    output logic [31:0] addr_out,
    output logic        fifo_flush,
    output logic        fifo_wr,
    output logic [23:0] fifo_wdata,
    output logic        busy,
    output logic        overrun
);

    localparam logic [4:0]  LEVEL_MAX   = 5'(FIFO_DEPTH - BURST);
    localparam logic [31:0] BURST_BYTES = 32'(BURST * 4);
    localparam logic [12:0] BURST_PIX   = 13'(BURST);
    localparam logic [1:0]  BEAT_LAST   = 2'(BURST - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ARB  = 3'd2,
        S_ADDR = 3'd3,
        S_DATA = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] line_addr_q, line_addr_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [12:0] line_cnt_q, line_cnt_d;
    logic [12:0] remaining_q, remaining_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic        pend_line_q, pend_line_d;
    logic        overrun_q, overrun_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            line_addr_q <= '0;
            cur_addr_q  <= '0;
            line_cnt_q  <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            pend_line_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            cur_addr_q  <= cur_addr_d;
            line_cnt_q  <= line_cnt_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            pend_line_q <= pend_line_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        cur_addr_d  = cur_addr_q;
        line_cnt_d  = line_cnt_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        pend_line_d = pend_line_q;
        overrun_d   = overrun_q;
        req         = 1'b0;
        cmd_out     = 3'b000;
        len_out     = 2'b00;
        addr_out    = '0;
        fifo_flush  = 1'b0;
        fifo_wr     = 1'b0;
        fifo_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pend_line_q) begin
                    pend_line_d = 1'b0;
                    if (line_cnt_q < vsize) begin
                        fifo_flush  = 1'b1;
                        remaining_d = hsize;
                        cur_addr_d  = line_addr_q;
                        line_addr_d = line_addr_q + lineinc;
                        line_cnt_d  = line_cnt_q + 13'd1;
                    end
                end else if (remaining_q != '0 && fifo_level <= LEVEL_MAX) begin
                    state_d = S_ARB;
                end
                if (!enable) state_d = S_IDLE;
            end
            S_ARB: begin
                req = 1'b1;
                if (gnt) state_d = S_ADDR;
            end
            S_ADDR: begin
                cmd_out     = 3'b010;
                len_out     = 2'b10;
                addr_out    = cur_addr_q;
                cur_addr_d  = cur_addr_q + BURST_BYTES;
                remaining_d = (remaining_q > BURST_PIX) ? remaining_q - BURST_PIX : '0;
                state_d     = S_DATA;
            end
            S_DATA: begin
                if (beat_valid) begin
                    fifo_wr    = 1'b1;
                    fifo_wdata = rd_data[23:0];
                    if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_d = '0;
                        state_d    = enable ? S_WAIT : S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new request arriving in the same cycle WAIT consumes the old one stays pending.
        if (line_start) pend_line_d = 1'b1;
        if ((pend_line_q && remaining_q != '0) || (line_start && pend_line_q)) overrun_d = 1'b1;

        // Frame restart wins over everything except an in-flight burst.
        if (frame_start) begin
            line_addr_d = base_addr;
            line_cnt_d  = '0;
            remaining_d = '0;
            pend_line_d = 1'b0;
            overrun_d   = 1'b0;
            fifo_flush  = 1'b0;
            if (state_d == S_ARB) state_d = S_WAIT;
        end
    end

    assign busy    = (state_q == S_ARB) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_vid_line_fetch_ctrl.sv
// Scoreboard bench for vid_line_fetch_ctrl: a line-level model queues expected burst
// addresses and beat data; a monitor compares them as the DUT presents them.
module tb_vid_line_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] lineinc = '0;
    logic [12:0] hsize = '0;
    logic [12:0] vsize = '0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [4:0]  fifo_level = '0;
    logic        gnt = 1'b0;
    logic        beat_valid;
    logic        beat_valid_resp = 1'b0;
    logic        beat_valid_stray = 1'b0;
    logic [31:0] rd_data = '0;
    logic        req;
    logic [2:0]  cmd_out;
    logic [1:0]  len_out;
    logic [31:0] addr_out;
    logic        fifo_flush;
    logic        fifo_wr;
    logic [23:0] fifo_wdata;
    logic        busy;
    logic        overrun;

    assign beat_valid = beat_valid_resp | beat_valid_stray;

    vid_line_fetch_ctrl #(.FIFO_DEPTH(16), .BURST(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .base_addr(base_addr),
        .lineinc(lineinc), .hsize(hsize), .vsize(vsize), .frame_start(frame_start),
        .line_start(line_start), .fifo_level(fifo_level), .gnt(gnt),
        .beat_valid(beat_valid), .rd_data(rd_data), .req(req), .cmd_out(cmd_out),
        .len_out(len_out), .addr_out(addr_out), .fifo_flush(fifo_flush),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr[$];
    logic [23:0] exp_data[$];
    int wr_count = 0;
    int flush_count = 0;
    int req_cycles = 0;
    int exp_flush = 0;
    int beats_sent = 0;
    int beat_limit = 4;
    logic [31:0] m_line_addr = '0;
    int m_line_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%08h, expected none", name, act);
    endtask

    // Monitor: every address cycle and FIFO write is matched against the scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (req) req_cycles++;
                if (fifo_flush) flush_count++;
                if (cmd_out != 3'b000 || len_out != 2'b00) begin
                    check("addr_cycle_cmd", 32'(cmd_out), 32'h2);
                    check("addr_cycle_len", 32'(len_out), 32'h2);
                    check("addr_cycle_req_low", 32'(req), 32'h0);
                    check("addr_cycle_busy", 32'(busy), 32'h1);
                    if (exp_addr.size() == 0) fail_now("unexpected_burst", addr_out);
                    else check("burst_addr", addr_out, exp_addr.pop_front());
                end else if (addr_out != 32'h0) begin
                    fail_now("addr_out_outside_addr_cycle", addr_out);
                end
                if (fifo_wr) begin
                    wr_count++;
                    if (exp_data.size() == 0) fail_now("unexpected_write", 32'(fifo_wdata));
                    else check("fifo_wdata", 32'(fifo_wdata), 32'(exp_data.pop_front()));
                end
            end
        end
    end

    // Bus slave: after each address cycle, returns beats with random gaps.
    initial begin : responder
        int b;
        forever begin
            @(negedge clk);
            if (reset_n && cmd_out == 3'b010) begin
                @(posedge clk); #1;
                b = 0;
                while (b < beat_limit) begin
                    if ($urandom_range(0, 2) == 0) begin
                        beat_valid_resp = 1'b0;
                    end else begin
                        beat_valid_resp = 1'b1;
                        rd_data = $urandom;
                        exp_data.push_back(rd_data[23:0]);
                        beats_sent++;
                        b++;
                    end
                    @(posedge clk); #1;
                end
                beat_valid_resp = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_frame_start();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        m_line_addr = base_addr;
        m_line_cnt = 0;
    endtask

    // Model of one line request: n_push < 0 queues every burst of the line.
    task automatic do_line_start(input string name, input int n_push);
        logic exp_fl;
        int nb;
        exp_fl = (m_line_cnt < int'(vsize));
        if (exp_fl) begin
            exp_flush++;
            nb = (int'(hsize) + 3) / 4;
            if (n_push >= 0 && n_push < nb) nb = n_push;
            for (int k = 0; k < nb; k++) exp_addr.push_back(m_line_addr + 32'(16 * k));
            m_line_addr = m_line_addr + lineinc;
            m_line_cnt++;
        end
        @(posedge clk); #1;
        line_start = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        line_start = 1'b0;
        @(negedge clk);
        check({name, "_flush"}, 32'(fifo_flush), 32'(exp_fl));
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_addr.size() == 0 && exp_data.size() == 0 && !busy && !req) && n < budget);
        if (n >= budget) fail_now({name, "_timeout"}, 32'(exp_addr.size() + exp_data.size()));
    endtask

    task automatic wait_beats(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (beats_sent < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail_now({name, "_timeout"}, 32'(beats_sent));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"}, 32'(req), 32'h0);
        check({tag, "_cmd"}, 32'(cmd_out), 32'h0);
        check({tag, "_len"}, 32'(len_out), 32'h0);
        check({tag, "_addr"}, addr_out, 32'h0);
        check({tag, "_flush"}, 32'(fifo_flush), 32'h0);
        check({tag, "_wr"}, 32'(fifo_wr), 32'h0);
        check({tag, "_wdata"}, 32'(fifo_wdata), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    initial begin : stimulus
        int wr0;
        int rq0;
        int b0;
        logic [31:0] la;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        #2 reset_n = 1'b1;

        // Line fetch: two bursts at 0x1000 / 0x1010
        base_addr = 32'h1000; lineinc = 32'h200; hsize = 13'd8; vsize = 13'd2;
        gnt = 1'b1; fifo_level = '0;
        @(posedge clk); #1 enable = 1'b1;
        do_frame_start();
        repeat (2) @(negedge clk);
        wr0 = wr_count;
        do_line_start("line0", -1);
        wait_quiet("line0", 200);
        check("line0_writes", 32'(wr_count - wr0), 32'd8);

        // Stride and vsize limit
        wr0 = wr_count;
        do_line_start("line1", -1);
        wait_quiet("line1", 200);
        check("line1_writes", 32'(wr_count - wr0), 32'd8);
        rq0 = req_cycles;
        wr0 = wr_count;
        do_line_start("line2_over_vsize", -1);
        @(posedge clk); #1 beat_valid_stray = 1'b1;
        repeat (3) @(posedge clk);
        #1 beat_valid_stray = 1'b0;
        repeat (6) @(negedge clk);
        check("over_vsize_req_cycles", 32'(req_cycles - rq0), 32'd0);
        check("stray_beat_writes", 32'(wr_count - wr0), 32'd0);
        check("frame1_flushes", 32'(flush_count), 32'(exp_flush));

        // FIFO throttle
        base_addr = $urandom & 32'hFFFF_FFF0;
        lineinc = ($urandom & 32'h0000_FFF0) | 32'h10;
        hsize = 13'd4; vsize = 13'd4;
        do_frame_start();
        fifo_level = 5'd13;
        do_line_start("throttle", -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("throttle_req_held", 32'(req), 32'h0);
        end
        @(posedge clk); #1 fifo_level = 5'd12;
        @(negedge clk);
        check("throttle_req_decision_cycle", 32'(req), 32'h0);
        @(negedge clk);
        check("throttle_req_rises", 32'(req), 32'h1);
        wait_quiet("throttle", 200);

        // Arbitration wait
        gnt = 1'b0; fifo_level = '0;
        do_line_start("arb", -1);
        begin
            int n;
            n = 0;
            while (!req && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) fail_now("arb_req_timeout", 32'(req));
        end
        for (int i = 0; i < 6; i++) begin
            check("arb_req_held", 32'(req), 32'h1);
            check("arb_cmd_idle", 32'(cmd_out), 32'h0);
            if (i < 5) @(negedge clk);
        end
        @(posedge clk); #1 gnt = 1'b1;
        @(negedge clk);
        check("arb_gnt_cycle_req", 32'(req), 32'h1);
        @(negedge clk);
        check("arb_after_gnt_cmd", 32'(cmd_out), 32'h2);
        check("arb_after_gnt_len", 32'(len_out), 32'h2);
        wait_quiet("arb", 200);

        // Overrun
        hsize = 13'd16; fifo_level = 5'd16;
        do_frame_start();
        do_line_start("ovr_first", 0);
        repeat (2) @(negedge clk);
        check("ovr_not_yet", 32'(overrun), 32'h0);
        do_line_start("ovr_second", 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ovr_sticky", 32'(overrun), 32'h1);
        end
        do_frame_start();
        @(negedge clk);
        check("ovr_cleared_by_frame", 32'(overrun), 32'h0);
        fifo_level = '0;
        rq0 = req_cycles;
        repeat (8) @(negedge clk);
        check("ovr_no_req_after_frame", 32'(req_cycles - rq0), 32'd0);

        // Mid-burst disable
        base_addr = $urandom & 32'hFFFF_FFF0;
        hsize = 13'd8;
        do_frame_start();
        la = m_line_addr;
        wr0 = wr_count;
        b0 = beats_sent;
        do_line_start("dis", 1);
        wait_beats("dis_two_beats", b0 + 2, 100);
        @(posedge clk); #1 enable = 1'b0;
        wait_quiet("dis_drain", 100);
        check("dis_writes", 32'(wr_count - wr0), 32'd4);
        rq0 = req_cycles;
        repeat (8) @(negedge clk);
        check("dis_idle_req_cycles", 32'(req_cycles - rq0), 32'd0);
        check("dis_idle_busy", 32'(busy), 32'h0);
        exp_addr.push_back(la + 32'h10);
        @(posedge clk); #1 enable = 1'b1;
        wait_quiet("dis_resume", 200);
        check("dis_resume_writes", 32'(wr_count - wr0), 32'd8);

        // Reset mid-DATA
        base_addr = $urandom & 32'hFFFF_FFF0;
        hsize = 13'd4;
        do_frame_start();
        beat_limit = 2;
        b0 = beats_sent;
        do_line_start("rst", -1);
        wait_beats("rst_two_beats", b0 + 2, 100);
        @(negedge clk);
        check("rst_in_data_busy", 32'(busy), 32'h1);
        #2 reset_n = 1'b0;
        beat_valid_stray = 1'b1;
        #1 check_outputs_zero("rst_mid_data");
        check("rst_beats_consumed", 32'(exp_data.size()), 32'd0);
        repeat (3) @(negedge clk);
        beat_valid_stray = 1'b0;
        beat_limit = 4;
        exp_addr.delete();
        exp_data.delete();
        #2 reset_n = 1'b1;
        rq0 = req_cycles;
        repeat (8) @(negedge clk);
        check("post_reset_req_cycles", 32'(req_cycles - rq0), 32'd0);
        check("post_reset_busy", 32'(busy), 32'h0);
        check("total_flushes", 32'(flush_count), 32'(exp_flush));
        check("scoreboard_addr_empty", 32'(exp_addr.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
